// File: rtl/filter_mac_if.sv
// rtl/filter_mac_if.sv - handshake/operand bundle between filter_mac and its upstream buffers and write-back stage
interface filter_mac_if #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
);
  logic             start;
  logic             filterReady;
  logic [DW-1:0]    filterIn;
  logic [DW-1:0]    dataIn;
  logic             rdEn;
  logic             busy;
  logic [ACC_W-1:0] result;
  logic             resultValid;

  modport master (
    output start, filterReady, filterIn, dataIn,
    input  rdEn, busy, result, resultValid
  );

  modport slave (
    input  start, filterReady, filterIn, dataIn,
    output rdEn, busy, result, resultValid
  );
endinterface

// File: rtl/filter_mac.sv
// rtl/filter_mac.sv - signed TAPS-element dot-product MAC with lock-step buffer read enable
// Optional feature: define MAC_RELU_EN to clamp negative results to zero.
module filter_mac #(
  parameter int TAPS  = 16,
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic         clk,
  input  logic         rstMac,
  filter_mac_if.slave  bus
);
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_rd_en;
  logic                    r_rd_en_d;
  logic                    r_busy;
  logic                    r_valid;
  logic [ACC_W-1:0]        r_result;

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_res;
  logic                    w_launch;

  assign w_prod     = $signed(bus.filterIn) * $signed(bus.dataIn);
  assign w_prod_ext = {{(ACC_W - 2*DW){w_prod[2*DW-1]}}, w_prod};
  // The last operand pair lands on the DRAIN->DONE edge, so result takes the post-add value.
  assign w_acc_next = r_rd_en_d ? (r_acc + w_prod_ext) : r_acc;
  assign w_launch   = bus.start && bus.filterReady;

`ifdef MAC_RELU_EN
  assign w_res = w_acc_next[ACC_W-1] ? '0 : w_acc_next;
`else
  assign w_res = w_acc_next;
`endif

  always_ff @(posedge clk) begin
    if (rstMac) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_en_d <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_result  <= '0;
    end else begin
      r_rd_en_d <= r_rd_en;
      r_valid   <= 1'b0;
      r_acc     <= w_acc_next;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state <= S_READ;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_result <= w_res;
        end
        S_DONE: begin
          if (w_launch) begin
            r_state <= S_READ;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_acc   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdEn        = r_rd_en;
  assign bus.busy        = r_busy;
  assign bus.result      = r_result;
  assign bus.resultValid = r_valid;
endmodule
